// File: rtl/oam_dma_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : oam_dma_pkg
// Brief   : Console CPU-bus register addresses and sprite DMA state encoding.
// Rev     : 1.0
//------------------------------------------------------------------------------
package oam_dma_pkg;

   localparam logic [15:0] c_TRIG_ADDR     = 16'h4014;
   localparam logic [15:0] c_OAM_DATA_ADDR = 16'h2004;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : oam_dma
// Brief   : Sprite DMA; snoops $4014 writes, pauses the CPU, copies one page
//           to the OAM data port as 256 read/write pairs.
// Rev     : 1.0
//------------------------------------------------------------------------------
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] TRIG_ADDR     = c_TRIG_ADDR,
   parameter logic [15:0] OAM_DATA_ADDR = c_OAM_DATA_ADDR
) (
   input  logic        i_CLK,
   input  logic        i_RST_N,
   input  logic [15:0] i_CPU_ADDR,
   input  logic [7:0]  i_CPU_DATA,
   input  logic        i_CPU_R_WN,
   input  logic [7:0]  i_BUS_DATA,
   output logic        o_PAUSE,
   output logic        o_DMA_ACTIVE,
   output logic [15:0] o_DMA_ADDR,
   output logic [7:0]  o_DMA_DATA,
   output logic        o_DMA_R_WN
);

   dma_state_t  r_state;
   logic [7:0]  r_page;
   logic [7:0]  r_idx;
   logic [7:0]  r_data;
   logic        r_par;
   logic        w_trigger;

   assign w_trigger  = (r_state == ST_IDLE) && !i_CPU_R_WN && (i_CPU_ADDR == TRIG_ADDR);

   // r_data is cleared whenever the engine leaves WRITE, so it doubles as the
   // write-data output register (zero outside WRITE).
   assign o_DMA_DATA = r_data;

   // Outputs are loaded together with the state they belong to, so every
   // output is a flop and nothing from the inputs reaches a port combinationally.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         r_state      <= ST_IDLE;
         r_page       <= 8'h00;
         r_idx        <= 8'h00;
         r_data       <= 8'h00;
         r_par        <= 1'b0;
         o_PAUSE      <= 1'b0;
         o_DMA_ACTIVE <= 1'b0;
         o_DMA_ADDR   <= 16'h0000;
         o_DMA_R_WN   <= 1'b1;
      end else begin
         r_par <= ~r_par;
         case (r_state)
            ST_IDLE: begin
               if (w_trigger) begin
                  r_state      <= ST_HALT;
                  r_page       <= i_CPU_DATA;
                  r_idx        <= 8'h00;
                  o_PAUSE      <= 1'b1;
                  o_DMA_ACTIVE <= 1'b1;
                  o_DMA_ADDR   <= {i_CPU_DATA, 8'h00};
                  o_DMA_R_WN   <= 1'b1;
               end
            end
            // Odd HALT goes straight to READ so every READ lands on an even cycle.
            ST_HALT:  r_state <= r_par ? ST_READ : ST_ALIGN;
            ST_ALIGN: r_state <= ST_READ;
            ST_READ: begin
               r_state    <= ST_WRITE;
               r_data     <= i_BUS_DATA;
               o_DMA_ADDR <= OAM_DATA_ADDR;
               o_DMA_R_WN <= 1'b0;
            end
            ST_WRITE: begin
               r_data     <= 8'h00;
               o_DMA_R_WN <= 1'b1;
               if (r_idx == 8'hFF) begin
                  r_state      <= ST_IDLE;
                  o_PAUSE      <= 1'b0;
                  o_DMA_ACTIVE <= 1'b0;
                  o_DMA_ADDR   <= 16'h0000;
               end else begin
                  r_state    <= ST_READ;
                  r_idx      <= r_idx + 8'd1;
                  o_DMA_ADDR <= {r_page, r_idx + 8'd1};
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_data       <= 8'h00;
               o_PAUSE      <= 1'b0;
               o_DMA_ACTIVE <= 1'b0;
               o_DMA_ADDR   <= 16'h0000;
               o_DMA_R_WN   <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
